hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Execute-stage consumer of the ALU's multiply/divide outputs.
- Sequences multi-cycle mult/multu/div/divu in the EXE stage and stalls the stage until the product or quotient is ready.
- Commits results to the architectural HI/LO registers and services mthi/mtlo/mfhi/mflo.
- Cancels in-flight operations on a pipeline flush, so a cancelled instruction never modifies HI/LO.

Parameters:
- MUL_LAT, 2, cycles from issue until mul_res is valid; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset (synchronous, active-high)
- es_valid  in  1  EXE stage holds a valid instruction
- hilo_op  in  8  one-hot {mflo,mfhi,mtlo,mthi,divu,div,multu,mult}, bit0=mult
- src1  in  32  rs value for mthi/mtlo
- mul_res  in  64  product {hi,lo} from ALU
- div_res  in  64  {quotient[63:32], remainder[31:0]} from ALU
- div_complete  in  1  divider result valid this cycle
- flush  in  1  exception/eret flush from WB; kills the EXE instruction
- es_ready_go  out  1  EXE instruction may leave the stage this cycle
- busy  out  1  state != IDLE
- div_cancel  out  1  abort pulse to the divider (ALU exception input)
- mf_result  out  32  HI or LO value for mfhi/mflo
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO

Behaviour:
- Reset: state=IDLE, cnt=0, HI=LO=0, busy=0, div_cancel=0, es_ready_go=1 (IDLE, no op), mf_result=0.
- Issue: es_valid & ~flush & op bit set. With es_valid=0, hilo_op is ignored entirely.
- States: IDLE, MUL, DIV.
- IDLE:
  - mult/multu issue -> MUL, cnt<=MUL_LAT-1, es_ready_go=0.
  - div/divu issue -> DIV, es_ready_go=0.
  - mthi: HI<=src1 at clock edge, es_ready_go=1.
  - mtlo: LO<=src1 at clock edge, es_ready_go=1.
  - mfhi/mflo: mf_result=HI/LO (combinational, pre-edge value), es_ready_go=1.
  - Any other instruction: es_ready_go=1.
- MUL:
  - cnt!=0: cnt<=cnt-1, es_ready_go=0.
  - cnt==0: HI<=mul_res[63:32], LO<=mul_res[31:0], es_ready_go=1, ->IDLE.
  - Total latency from issue cycle t: ready_go at t+MUL_LAT; new HI/LO visible at t+MUL_LAT+1.
  - MUL_LAT=1 gives ready_go at t+1.
- DIV:
  - div_complete=0: stay, es_ready_go=0.
  - div_complete=1: LO<=div_res[63:32] (quotient), HI<=div_res[31:0] (remainder), es_ready_go=1, ->IDLE.
- Flush:
  - In MUL or DIV: ->IDLE next cycle, no HI/LO write, es_ready_go=0 that cycle.
  - div_cancel=1 for exactly that cycle when the state is DIV.
  - Flush has priority over a same-cycle cnt==0 or div_complete.
  - In IDLE: suppresses issue and any mthi/mtlo write.
- div_complete while in IDLE or MUL: ignored.
- Operands are held stable by the stall; the block does not latch src1/mul_res before commit.
- A new hilo op cannot be issued while busy (EXE is stalled); hilo_op changes while busy are ignored.
- Reset mid-operation: immediate return to reset values; no partial commit.
- Only one hilo_op bit may be set; multi-hot input is undefined. Verification applies a one-hot assertion.

Test Plan:
- Mult, MUL_LAT=2: issue mult with mul_res=0xFFFFFFFF_FFFFFFFA (-2*3) at t -> es_ready_go=0 at t,t+1 and 1 at t+2; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA at t+3; busy=1 at t+1,t+2.
- Divu: issue divu, div_res={0x00000003,0x00000001}, div_complete pulsed at t+33 -> es_ready_go high only at t+33; lo_out=3, hi_out=1 at t+34.
- Flush mid-div: HI=LO=0x55 preset; issue div, flush at t+10 -> div_cancel=1 at t+10, IDLE at t+11, HI/LO remain 0x55; a stray div_complete at t+20 causes no write.
- Move/from: mthi src1=0x12345678, then mflo/mfhi next cycles -> HI=0x12345678 after edge; mfhi mf_result=0x12345678, es_ready_go=1 same cycle; mflo returns the unchanged LO.
- Flush vs completion: in MUL with cnt==0 and flush=1 same cycle -> no HI/LO write, es_ready_go=0, IDLE next.
- Reset and es_valid: reset asserted during MUL -> next cycle IDLE, HI=LO=0, busy=0; hilo_op=mthi with es_valid=0 -> HI unchanged.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: EXE-stage HI/LO register file and multiply/divide sequencer.
// Waits on the ALU's multi-cycle multiply/divide, stalling the EXE stage
// until the result is ready, then commits it to HI/LO. Also services
// mthi/mtlo/mfhi/mflo. A pipeline flush cancels any in-flight operation
// without touching HI/LO.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   es_valid        EXE stage holds a valid instruction
//   hilo_op[7:0]    one-hot {mflo,mfhi,mtlo,mthi,divu,div,multu,mult}
//   src1[31:0]      rs value for mthi/mtlo
//   mul_res[63:0]   product {hi,lo} from the ALU
//   div_res[63:0]   {quotient, remainder} from the ALU
//   div_complete    divider result valid this cycle
//   flush           kills the EXE instruction
//   es_ready_go     EXE instruction may leave the stage this cycle
//   busy            a multiply/divide is in flight
//   div_cancel      abort pulse to the divider
//   mf_result[31:0] HI or LO for mfhi/mflo
//   hi_out, lo_out  architectural HI/LO
module hilo_unit #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic [7:0]  hilo_op,
    input  logic [31:0] src1,
    input  logic [63:0] mul_res,
    input  logic [63:0] div_res,
    input  logic        div_complete,
    input  logic        flush,
    output logic        es_ready_go,
    output logic        busy,
    output logic        div_cancel,
    output logic [31:0] mf_result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    // Counter is loaded with MUL_LAT-1 so mul_res is committed on the
    // cycle the count reaches zero.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic        issue;

    assign issue  = es_valid & ~flush;
    assign busy   = (state_q != S_IDLE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        es_ready_go = 1'b0;
        div_cancel  = 1'b0;
        mf_result   = '0;

        unique case (state_q)
            S_IDLE: begin
                es_ready_go = 1'b1;
                if (issue) begin
                    if (hilo_op[0] | hilo_op[1]) begin
                        state_d     = S_MUL;
                        cnt_d       = CNT_INIT;
                        es_ready_go = 1'b0;
                    end else if (hilo_op[2] | hilo_op[3]) begin
                        state_d     = S_DIV;
                        es_ready_go = 1'b0;
                    end
                    if (hilo_op[4]) hi_d = src1;
                    if (hilo_op[5]) lo_d = src1;
                    if (hilo_op[6]) mf_result = hi_q;
                    if (hilo_op[7]) mf_result = lo_q;
                end
            end

            S_MUL: begin
                // Flush wins over a same-cycle commit.
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    hi_d        = mul_res[63:32];
                    lo_d        = mul_res[31:0];
                    es_ready_go = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DIV: begin
                if (flush) begin
                    div_cancel = 1'b1;
                    state_d    = S_IDLE;
                end else if (div_complete) begin
                    lo_d        = div_res[63:32];
                    hi_d        = div_res[31:0];
                    es_ready_go = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized scoreboard bench for hilo_unit. A driver issues one instruction
// at a time, computes the architectural outcome from a plain HI/LO model and
// pushes it; a monitor pops on every retire/flush and checks it.
module tb_hilo_unit;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [7:0]  hilo_op;
    logic [31:0] src1;
    logic [63:0] mul_res;
    logic [63:0] div_res;
    logic        div_complete;
    logic        flush;
    logic        es_ready_go;
    logic        busy;
    logic        div_cancel;
    logic [31:0] mf_result;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    always #5 clk = ~clk;

    hilo_unit #(.MUL_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .es_valid     (es_valid),
        .hilo_op      (hilo_op),
        .src1         (src1),
        .mul_res      (mul_res),
        .div_res      (div_res),
        .div_complete (div_complete),
        .flush        (flush),
        .es_ready_go  (es_ready_go),
        .busy         (busy),
        .div_cancel   (div_cancel),
        .mf_result    (mf_result),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    typedef struct {
        int unsigned k;       // stall cycles before the retire/flush cycle
        logic        rdy;
        logic        bsy;
        logic        dcan;
        logic        chk_mf;
        logic [31:0] mf;
        logic [31:0] hi;      // HI/LO expected on the following cycle
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (es_valid) assert ($onehot0(hilo_op));
    end

    // Monitor
    int unsigned stall_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_hi, pend_lo;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_cnt = 0;
            pend      = 1'b0;
        end else begin
            if (pend) begin
                check("post_hi", hi_out, pend_hi);
                check("post_lo", lo_out, pend_lo);
                check("post_busy", busy, 1'b0);
                pend = 1'b0;
            end
            if (es_valid && (es_ready_go || flush)) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_retire: got event, expected none");
                end else begin
                    e = sb.pop_front();
                    check("latency", stall_cnt, e.k);
                    check("ready_go", es_ready_go, e.rdy);
                    check("busy", busy, e.bsy);
                    check("div_cancel", div_cancel, e.dcan);
                    if (e.chk_mf) check("mf_result", mf_result, e.mf);
                    pend    = 1'b1;
                    pend_hi = e.hi;
                    pend_lo = e.lo;
                end
                stall_cnt = 0;
            end else if (es_valid) begin
                stall_cnt++;
            end
        end
    end

    // Driver: called at posedge+1; returns at posedge+1.
    task automatic run_instr(input int fop);
        int unsigned op, d, f, stall, g;
        logic        do_fl, is_div;
        logic [31:0] a, b, q, r;
        int          sa, sbv;
        exp_t        e;

        op = (fop < 0) ? $urandom_range(0, 8) : fop;
        a  = $urandom;
        b  = $urandom;
        if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
        sa  = a;
        sbv = b;
        mul_res = (op == 0) ? 64'(longint'(sa) * longint'(sbv)) : 64'(a) * 64'(b);
        if (op == 2) begin
            q = 32'(sa / sbv);
            r = 32'(sa % sbv);
        end else begin
            q = a / b;
            r = a % b;
        end
        div_res = {q, r};
        is_div  = (op == 2 || op == 3);
        d       = $urandom_range(1, 40);
        stall   = (op < 2) ? LAT : (is_div ? d : 0);
        do_fl   = (fop < 0) && ($urandom_range(0, 3) == 0);
        f       = $urandom_range(0, stall);

        e.chk_mf = 1'b0;
        e.mf     = '0;
        e.dcan   = 1'b0;
        if (do_fl) begin
            e.k    = f;
            e.rdy  = (f == 0);
            e.bsy  = (f != 0);
            e.dcan = is_div && (f != 0);
        end else begin
            e.k   = stall;
            e.rdy = 1'b1;
            e.bsy = (stall != 0);
            case (op)
                0, 1: begin m_hi = mul_res[63:32]; m_lo = mul_res[31:0]; end
                2, 3: begin m_lo = q; m_hi = r; end
                4: m_hi = a;
                5: m_lo = a;
                6: begin e.chk_mf = 1'b1; e.mf = m_hi; end
                7: begin e.chk_mf = 1'b1; e.mf = m_lo; end
                default: ;
            endcase
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);

        es_valid = 1'b1;
        hilo_op  = (op < 8) ? 8'(1 << op) : 8'h00;
        src1     = a;
        for (int k = 0; ; k++) begin
            flush        = do_fl && (k == f);
            div_complete = is_div ? (k == d) : ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (es_ready_go || flush) break;
            if (k >= 200) begin
                tests++;
                fails++;
                $display("FAIL timeout: got no ready_go after %0d cycles, expected %0d", k, stall);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        es_valid     = 1'b0;
        flush        = 1'b0;
        div_complete = 1'b0;
        // Idle gap: junk ops and stray div_complete must be ignored.
        g = $urandom_range(0, 2);
        for (int unsigned gi = 0; gi < g; gi++) begin
            hilo_op      = 8'(1 << $urandom_range(0, 7));
            src1         = $urandom;
            div_complete = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        div_complete = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        es_valid     = 1'b0;
        hilo_op      = '0;
        src1         = '0;
        mul_res      = '0;
        div_res      = '0;
        div_complete = 1'b0;
        flush        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_ready_go", es_ready_go, 1'b1);
        check("rst_div_cancel", div_cancel, 1'b0);
        check("rst_mf_result", mf_result, 32'h0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int unsigned n = 0; n < 300; n++) run_instr(-1);

        // Reset in the middle of a multiply.
        run_instr(4);
        run_instr(5);
        es_valid = 1'b1;
        hilo_op  = 8'h01;
        mul_res  = 64'hFFFF_FFFF_FFFF_FFFA;
        @(posedge clk);
        #1;
        es_valid = 1'b0;
        hilo_op  = '0;
        reset    = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        @(negedge clk);
        check("rst_mul_busy", busy, 1'b0);
        check("rst_mul_hi", hi_out, 32'h0);
        check("rst_mul_lo", lo_out, 32'h0);
        check("rst_mul_ready_go", es_ready_go, 1'b1);

        // mthi without es_valid must not write HI.
        @(posedge clk);
        #1;
        hilo_op = 8'h10;
        src1    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        hilo_op = '0;
        @(negedge clk);
        check("novalid_mthi_hi", hi_out, m_hi);

        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drained: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
